// File: rtl/voice_mixer.sv
// Gain-weighted N-voice mixer: one shared MAC walks a per-sample snapshot of
// the voices, saturates the mono sum, then splits it to L/R with static or LFO pan.
module voice_mixer #(
  parameter int NUM_VOICES = 8,
  parameter int DATA_W     = 16,
  parameter int GAIN_W     = 9,
  parameter int PAN_W      = 8
) (
  input  logic                         Clk,
  input  logic                         Reset_n,
  input  logic                         sample_strobe,
  input  logic [NUM_VOICES*DATA_W-1:0] voices_in,
  input  logic [NUM_VOICES*GAIN_W-1:0] gains_in,
  input  logic [PAN_W-1:0]             master_pan,
  input  logic                         auto_pan_en,
  input  logic [15:0]                  auto_pan_step,
  output logic signed [DATA_W-1:0]     ldata_out,
  output logic signed [DATA_W-1:0]     rdata_out,
  output logic                         out_valid,
  output logic                         busy,
  output logic                         clip,
  output logic                         overrun
);

  localparam int IDX_W  = $clog2(NUM_VOICES);
  localparam int ACC_W  = DATA_W + GAIN_W + IDX_W;
  localparam int PROD_W = DATA_W + GAIN_W + 1;
  localparam int PANP_W = DATA_W + PAN_W + 2;

  typedef enum logic [1:0] {IDLE, ACCUM, SAT, PAN} state_t;

  state_t                         state_q, state_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic signed [ACC_W-1:0]        acc_q, acc_d;
  logic [NUM_VOICES*DATA_W-1:0]   voices_q, voices_d;
  logic [NUM_VOICES*GAIN_W-1:0]   gains_q, gains_d;
  logic [PAN_W-1:0]               pan_q, pan_d;
  logic                           pan_en_q, pan_en_d;
  logic [15:0]                    step_q, step_d;
  logic [15:0]                    phase_q, phase_d;
  logic signed [DATA_W-1:0]       mono_q, mono_d;
  logic                           clip_pend_q, clip_pend_d;
  logic signed [DATA_W-1:0]       ldata_q, ldata_d, rdata_q, rdata_d;
  logic                           out_valid_q, out_valid_d;
  logic                           clip_q, clip_d;
  logic                           overrun_q, overrun_d;

  logic signed [DATA_W-1:0]       voice_sel;
  logic [GAIN_W-1:0]              gain_sel;
  logic signed [PROD_W-1:0]       prod;
  logic signed [ACC_W-1:0]        shifted;
  logic [ACC_W-DATA_W:0]          hi_bits;
  logic [PAN_W-1:0]               tri_p, pan_p;
  logic [PAN_W:0]                 gl, gr;
  logic signed [PANP_W-1:0]       lprod, rprod;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      voices_q    <= '0;
      gains_q     <= '0;
      pan_q       <= '0;
      pan_en_q    <= 1'b0;
      step_q      <= '0;
      phase_q     <= '0;
      mono_q      <= '0;
      clip_pend_q <= 1'b0;
      ldata_q     <= '0;
      rdata_q     <= '0;
      out_valid_q <= 1'b0;
      clip_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      voices_q    <= voices_d;
      gains_q     <= gains_d;
      pan_q       <= pan_d;
      pan_en_q    <= pan_en_d;
      step_q      <= step_d;
      phase_q     <= phase_d;
      mono_q      <= mono_d;
      clip_pend_q <= clip_pend_d;
      ldata_q     <= ldata_d;
      rdata_q     <= rdata_d;
      out_valid_q <= out_valid_d;
      clip_q      <= clip_d;
      overrun_q   <= overrun_d;
    end
  end

  // Datapath terms shared by the FSM below.
  always_comb begin
    voice_sel = voices_q[int'(idx_q)*DATA_W +: DATA_W];
    gain_sel  = gains_q[int'(idx_q)*GAIN_W +: GAIN_W];
    prod      = voice_sel * $signed({1'b0, gain_sel});
    shifted   = acc_q >>> (GAIN_W - 1);
    hi_bits   = shifted[ACC_W-1:DATA_W-1];
    tri_p     = phase_q[15] ? ~phase_q[14 -: PAN_W] : phase_q[14 -: PAN_W];
    pan_p     = pan_en_q ? tri_p : pan_q;
    gl        = {1'b1, {PAN_W{1'b0}}} - {1'b0, pan_p};
    gr        = {1'b0, pan_p};
    lprod     = mono_q * $signed({1'b0, gl});
    rprod     = mono_q * $signed({1'b0, gr});
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    voices_d    = voices_q;
    gains_d     = gains_q;
    pan_d       = pan_q;
    pan_en_d    = pan_en_q;
    step_d      = step_q;
    phase_d     = phase_q;
    mono_d      = mono_q;
    clip_pend_d = clip_pend_q;
    ldata_d     = ldata_q;
    rdata_d     = rdata_q;
    out_valid_d = 1'b0;
    clip_d      = 1'b0;
    overrun_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (sample_strobe) begin
          voices_d = voices_in;
          gains_d  = gains_in;
          pan_d    = master_pan;
          pan_en_d = auto_pan_en;
          step_d   = auto_pan_step;
          acc_d    = '0;
          idx_d    = '0;
          state_d  = ACCUM;
        end
      end
      ACCUM: begin
        acc_d = acc_q + ACC_W'(prod);
        if (idx_q == IDX_W'(NUM_VOICES - 1)) begin
          idx_d   = '0;
          state_d = SAT;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      SAT: begin
        // In range only when every bit above the mono sign bit matches it.
        if ((&hi_bits) || !(|hi_bits)) begin
          mono_d      = DATA_W'(shifted);
          clip_pend_d = 1'b0;
        end else begin
          mono_d      = shifted[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                         : {1'b0, {(DATA_W-1){1'b1}}};
          clip_pend_d = 1'b1;
        end
        state_d = PAN;
      end
      PAN: begin
        ldata_d     = DATA_W'(lprod >>> PAN_W);
        rdata_d     = DATA_W'(rprod >>> PAN_W);
        out_valid_d = 1'b1;
        clip_d      = clip_pend_q;
        if (pan_en_q) phase_d = phase_q + step_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (sample_strobe && (state_q != IDLE)) overrun_d = 1'b1;
  end

  assign ldata_out = ldata_q;
  assign rdata_out = rdata_q;
  assign out_valid = out_valid_q;
  assign clip      = clip_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_voice_mixer.sv
// Scoreboard bench for voice_mixer: a behavioural model queues expected L/R/clip
// and arrival cycle per accepted strobe; the output monitor pops and compares.
module tb_voice_mixer;

  localparam int NV = 8;
  localparam int DW = 16;
  localparam int GW = 9;
  localparam int PW = 8;

  logic                   Clk = 1'b0;
  logic                   Reset_n;
  logic                   sample_strobe;
  logic [NV*DW-1:0]       voices_in;
  logic [NV*GW-1:0]       gains_in;
  logic [PW-1:0]          master_pan;
  logic                   auto_pan_en;
  logic [15:0]            auto_pan_step;
  logic signed [DW-1:0]   ldata, rdata;
  logic                   out_valid, busy, clip, overrun;

  voice_mixer #(.NUM_VOICES(NV), .DATA_W(DW), .GAIN_W(GW), .PAN_W(PW)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .sample_strobe(sample_strobe),
    .voices_in(voices_in), .gains_in(gains_in), .master_pan(master_pan),
    .auto_pan_en(auto_pan_en), .auto_pan_step(auto_pan_step),
    .ldata_out(ldata), .rdata_out(rdata), .out_valid(out_valid),
    .busy(busy), .clip(clip), .overrun(overrun)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {int l; int r; int c; int t;} exp_t;
  exp_t sb[$];

  int n_chk = 0;
  int n_pass = 0;
  int bench_phase = 0;
  int cur_v[NV];
  int cur_g[NV];
  bit ovr_en = 1'b0;
  int ovr_l, ovr_r;

  task automatic check(string tag, int got, int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  function automatic exp_t model(int pan, bit en, int step);
    exp_t e;
    longint acc, m;
    int p, f;
    acc = 0;
    for (int i = 0; i < NV; i++) acc += longint'(cur_v[i]) * longint'(cur_g[i]);
    m = acc >>> (GW - 1);
    e.c = 0;
    if (m > 32767)  begin m = 32767;  e.c = 1; end
    if (m < -32768) begin m = -32768; e.c = 1; end
    f = (bench_phase >> 7) & 255;
    p = en ? ((((bench_phase >> 15) & 1) != 0) ? 255 - f : f) : pan;
    e.l = int'((m * longint'(256 - p)) >>> 8);
    e.r = int'((m * longint'(p)) >>> 8);
    e.t = 0;
    if (en) bench_phase = (bench_phase + step) & 16'hFFFF;
    return e;
  endfunction

  // Called just after a negedge; leaves the bench at the following negedge.
  task automatic send(int pan, bit en, int step, bit accept);
    exp_t e;
    for (int i = 0; i < NV; i++) begin
      voices_in[i*DW +: DW] = cur_v[i][DW-1:0];
      gains_in[i*GW +: GW]  = cur_g[i][GW-1:0];
    end
    master_pan    = pan[PW-1:0];
    auto_pan_en   = en;
    auto_pan_step = step[15:0];
    sample_strobe = 1'b1;
    if (accept) begin
      e = model(pan, en, step);
      e.t = cyc + 11;
      if (ovr_en) begin e.l = ovr_l; e.r = ovr_r; end
      sb.push_back(e);
    end
    @(negedge Clk);
    sample_strobe = 1'b0;
    for (int i = 0; i < NV; i++) begin
      voices_in[i*DW +: DW] = DW'($urandom);
      gains_in[i*GW +: GW]  = GW'($urandom);
    end
  endtask

  task automatic drain();
    int b = 0;
    while (sb.size() != 0 && b < 40) begin
      @(negedge Clk);
      b++;
    end
    check("drain", sb.size(), 0);
    @(negedge Clk);
  endtask

  task automatic set_all(int v, int g);
    for (int i = 0; i < NV; i++) begin cur_v[i] = v; cur_g[i] = g; end
  endtask

  always @(negedge Clk) begin
    exp_t e;
    if (Reset_n && out_valid) begin
      if (sb.size() == 0) check("unexpected_valid", 1, 0);
      else begin
        e = sb.pop_front();
        check("L", int'(ldata), e.l);
        check("R", int'(rdata), e.r);
        check("clip", int'(clip), e.c);
        check("latency", cyc, e.t);
      end
    end
    if (clip && !out_valid) check("clip_pulse", 1, 0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    Reset_n = 1'b0; sample_strobe = 1'b0; voices_in = '0; gains_in = '0;
    master_pan = '0; auto_pan_en = 1'b0; auto_pan_step = '0;
    set_all(0, 256);

    // Reset held with strobes applied
    repeat (3) @(negedge Clk);
    sample_strobe = 1'b1;
    repeat (3) @(negedge Clk);
    check("rst_l", int'(ldata), 0);
    check("rst_r", int'(rdata), 0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_clip", int'(clip), 0);
    check("rst_overrun", int'(overrun), 0);
    sample_strobe = 1'b0;
    Reset_n = 1'b1;
    @(negedge Clk);

    // Single voice, hard left
    cur_v[0] = 1000;
    send(0, 1'b0, 0, 1'b1);
    check("busy_run", int'(busy), 1);
    drain();
    check("idle_after", int'(busy), 0);

    // Positive and negative saturation at centre pan
    set_all(8000, 256);
    send(128, 1'b0, 0, 1'b1);
    drain();
    set_all(-8000, 256);
    send(128, 1'b0, 0, 1'b1);
    drain();

    // Dropped strobe during processing
    for (int i = 0; i < NV; i++) begin
      cur_v[i] = int'($urandom_range(0, 65535)) - 32768;
      cur_g[i] = int'($urandom_range(0, 511));
    end
    send(77, 1'b0, 0, 1'b1);
    repeat (2) @(negedge Clk);
    sample_strobe = 1'b1;
    @(negedge Clk);
    sample_strobe = 1'b0;
    check("overrun_pulse", int'(overrun), 1);
    @(negedge Clk);
    check("overrun_clear", int'(overrun), 0);
    drain();

    // Strobe accepted on the out_valid cycle
    set_all(1234, 300);
    send(200, 1'b0, 0, 1'b1);
    b = 0;
    while (!out_valid && b < 30) begin @(negedge Clk); b++; end
    check("valid_seen", int'(out_valid), 1);
    set_all(-5000, 100);
    send(30, 1'b0, 0, 1'b1);
    drain();

    // Random patterns
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < NV; i++) begin
        cur_v[i] = int'($urandom_range(0, 65535)) - 32768;
        cur_g[i] = int'($urandom_range(0, 511));
      end
      send(int'($urandom_range(0, 255)), 1'b0, 0, 1'b1);
      drain();
    end

    // LFO auto-pan from phase 0; fixed anchor values at samples 65 and 257
    set_all(0, 256);
    cur_v[0] = 1000;
    for (int n = 1; n <= 257; n++) begin
      ovr_en = (n == 65) || (n == 257);
      ovr_l  = (n == 65) ? 750 : 3;
      ovr_r  = (n == 65) ? 250 : 996;
      send(0, 1'b1, 16'h0080, 1'b1);
      drain();
    end
    ovr_en = 1'b0;

    // Reset during ACCUM abandons the sample and clears the LFO phase
    set_all(2000, 256);
    send(0, 1'b1, 16'h0080, 1'b1);
    repeat (3) @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    check("mid_rst_l", int'(ldata), 0);
    check("mid_rst_r", int'(rdata), 0);
    check("mid_rst_busy", int'(busy), 0);
    sb.delete();
    bench_phase = 0;
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (12) @(negedge Clk);
    check("no_valid_after_rst", int'(out_valid), 0);
    set_all(0, 256);
    cur_v[0] = 1000;
    send(0, 1'b1, 16'h0080, 1'b1);
    drain();
    send(0, 1'b1, 16'h4000, 1'b1);
    drain();
    send(0, 1'b1, 16'h0080, 1'b1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
